// File: rtl/morse_key_classifier_pkg.sv
// Shared state encoding and default Morse unit timing, also used by the downstream decoder.
package morse_key_classifier_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPress = 2'd1,
      StGap   = 2'd2
   } state_e;

   // 100 ms per unit at 50 MHz
   localparam int unsigned DefClkPerUnit     = 5000000;
   localparam int unsigned DefDashUnits      = 2;
   localparam int unsigned DefLetterGapUnits = 2;
   localparam int unsigned DefWordGapUnits   = 5;

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler producing one unit_tick per Morse unit, plus a saturating count of elapsed units.
module morse_unit_timer
   import morse_key_classifier_pkg::*;
#(
   parameter int unsigned CLK_PER_UNIT   = DefClkPerUnit,
   parameter int unsigned WORD_GAP_UNITS = DefWordGapUnits,
   parameter int unsigned UNIT_W         = $clog2(WORD_GAP_UNITS + 1)
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              clear,
   input  logic              enable,
   output logic              unit_tick,
   output logic [UNIT_W-1:0] unit_cnt
);

   localparam int unsigned PW = $clog2(CLK_PER_UNIT);
   localparam logic [PW-1:0]     PrescLast = PW'(CLK_PER_UNIT - 1);
   localparam logic [UNIT_W-1:0] UnitMax   = UNIT_W'(WORD_GAP_UNITS);

   logic [PW-1:0] presc_q;

   assign unit_tick = enable && (presc_q == PrescLast);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         presc_q  <= '0;
         unit_cnt <= '0;
      end else if (clear) begin
         presc_q  <= '0;
         unit_cnt <= '0;
      end else if (enable) begin
         presc_q <= unit_tick ? '0 : presc_q + PW'(1);
         if (unit_tick && (unit_cnt != UnitMax)) begin
            unit_cnt <= unit_cnt + UNIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/morse_key_classifier.sv
// Classifies conditioned key presses into dot/dash symbols and flags letter and word gaps.
module morse_key_classifier
   import morse_key_classifier_pkg::*;
#(
   parameter int unsigned CLK_PER_UNIT     = DefClkPerUnit,
   parameter int unsigned DASH_UNITS       = DefDashUnits,
   parameter int unsigned LETTER_GAP_UNITS = DefLetterGapUnits,
   parameter int unsigned WORD_GAP_UNITS   = DefWordGapUnits
) (
   input  logic clk,
   input  logic clrn,
   input  logic key_in,
   output logic sym_valid,
   output logic sym_is_dash,
   output logic letter_end,
   output logic word_end,
   output logic busy
);

   localparam int unsigned UnitW = $clog2(WORD_GAP_UNITS + 1);
   localparam logic [UnitW-1:0] DashCnt   = UnitW'(DASH_UNITS);
   localparam logic [UnitW-1:0] DashM1    = UnitW'(DASH_UNITS - 1);
   localparam logic [UnitW-1:0] LetterM1  = UnitW'(LETTER_GAP_UNITS - 1);
   localparam logic [UnitW-1:0] WordM1    = UnitW'(WORD_GAP_UNITS - 1);

   state_e           state_q, state_d;
   logic             sync1_q, key_s, key_prev;
   logic [1:0]       prime_q;
   logic             rise, fall;
   logic             timer_clear, unit_tick;
   logic [UnitW-1:0] unit_cnt;
   logic             letter_done_q, letter_done_d;
   logic             letter_hit, word_hit, dash_hit;
   logic             sym_valid_d, sym_is_dash_d, letter_end_d, word_end_d;

   // key_prev stays high until the synchronizer has refilled, so a key held through reset
   // only counts once it has been released.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync1_q  <= 1'b0;
         key_s    <= 1'b0;
         prime_q  <= 2'b00;
         key_prev <= 1'b1;
      end else begin
         sync1_q  <= key_in;
         key_s    <= sync1_q;
         prime_q  <= {prime_q[0], 1'b1};
         key_prev <= prime_q[1] ? key_s : 1'b1;
      end
   end

   assign rise = key_s & ~key_prev;
   assign fall = ~key_s & key_prev;

   morse_unit_timer #(
      .CLK_PER_UNIT   (CLK_PER_UNIT),
      .WORD_GAP_UNITS (WORD_GAP_UNITS),
      .UNIT_W         (UnitW)
   ) u_timer (
      .clk       (clk),
      .clrn      (clrn),
      .clear     (timer_clear),
      .enable    (state_q != StIdle),
      .unit_tick (unit_tick),
      .unit_cnt  (unit_cnt)
   );

   // A tick landing in the fall cycle still counts toward the press length.
   assign dash_hit   = (unit_cnt >= DashCnt) || (unit_tick && (unit_cnt == DashM1));
   assign letter_hit = (state_q == StGap) && !rise && !letter_done_q && unit_tick &&
                       (unit_cnt == LetterM1);
   assign word_hit   = (state_q == StGap) && !rise && unit_tick && (unit_cnt == WordM1);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q       <= StIdle;
         letter_done_q <= 1'b0;
         sym_valid     <= 1'b0;
         sym_is_dash   <= 1'b0;
         letter_end    <= 1'b0;
         word_end      <= 1'b0;
      end else begin
         state_q       <= state_d;
         letter_done_q <= letter_done_d;
         sym_valid     <= sym_valid_d;
         sym_is_dash   <= sym_is_dash_d;
         letter_end    <= letter_end_d;
         word_end      <= word_end_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (rise) state_d = StPress;
         StPress: if (fall) state_d = StGap;
         StGap: begin
            if (rise) begin
               state_d = StPress;
            end else if (word_hit) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      timer_clear   = (state_q == StIdle) || (state_d != state_q);
      letter_done_d = (state_q == StGap) && !rise && (letter_done_q || letter_hit);
   end

   always_comb begin
      sym_valid_d   = (state_q == StPress) && fall;
      sym_is_dash_d = sym_valid_d && dash_hit;
      letter_end_d  = letter_hit;
      word_end_d    = word_hit;
   end

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier with a 4-cycle unit; pulses are counted per window.
module tb_morse_key_classifier;

   logic clk = 1'b0;
   logic clrn;
   logic key_in;
   logic sym_valid, sym_is_dash, letter_end, word_end, busy;

   int checks = 0;
   int errors = 0;
   int n_sym = 0, n_dash = 0, n_letter = 0, n_word = 0, n_bad = 0;
   int b_sym, b_dash, b_letter, b_word;

   always #5 clk = ~clk;

   morse_key_classifier #(
      .CLK_PER_UNIT     (4),
      .DASH_UNITS       (2),
      .LETTER_GAP_UNITS (2),
      .WORD_GAP_UNITS   (5)
   ) dut (
      .clk         (clk),
      .clrn        (clrn),
      .key_in      (key_in),
      .sym_valid   (sym_valid),
      .sym_is_dash (sym_is_dash),
      .letter_end  (letter_end),
      .word_end    (word_end),
      .busy        (busy)
   );

   function automatic logic [4:0] outs();
      return {sym_valid, sym_is_dash, letter_end, word_end, busy};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if (sym_valid) n_sym++;
         if (sym_valid && sym_is_dash) n_dash++;
         if (sym_is_dash && !sym_valid) n_bad++;
         if (letter_end) n_letter++;
         if (word_end) n_word++;
         if (int'(sym_valid) + int'(letter_end) + int'(word_end) > 1) n_bad++;
      end
   endtask

   task automatic mark();
      b_sym    = n_sym;
      b_dash   = n_dash;
      b_letter = n_letter;
      b_word   = n_word;
   endtask

   task automatic press(input int n);
      key_in = 1'b1;
      run(n);
      key_in = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clrn   = 1'b0;
      key_in = 1'b0;

      // Reset with key activity
      for (int i = 0; i < 6; i++) begin
         key_in = ~key_in;
         step();
         chk("reset_hold", outs(), 5'b00000);
      end
      key_in = 1'b0;
      clrn   = 1'b1;
      mark();
      run(10);
      chk("post_reset_pulses", n_sym + n_letter + n_word - b_sym - b_letter - b_word, 0);
      chk("post_reset_busy", busy, 1'b0);

      // Dot then word gap
      press(4);
      step();
      step();
      chk("dot_pre", outs(), 5'b00001);
      step();
      chk("dot_sym", outs(), 5'b10001);
      mark();
      run(7);
      chk("dot_letter_early", n_letter - b_letter, 0);
      step();
      chk("dot_letter", outs(), 5'b00101);
      mark();
      run(11);
      chk("dot_word_early", n_word - b_word, 0);
      step();
      chk("dot_word", outs(), 5'b00010);
      run(4);
      chk("dot_idle", outs(), 5'b00000);

      // Dash boundary
      press(8);
      step();
      step();
      step();
      chk("dash8", outs(), 5'b11001);
      mark();
      run(25);
      chk("dash8_letter", n_letter - b_letter, 1);
      chk("dash8_word", n_word - b_word, 1);
      chk("dash8_idle", busy, 1'b0);
      press(7);
      step();
      step();
      step();
      chk("dot7", outs(), 5'b10001);
      run(25);

      // Intra-letter gap of 5 cycles
      press(4);
      step();
      step();
      step();
      chk("il_sym1", outs(), 5'b10001);
      mark();
      run(2);
      press(8);
      run(2);
      step();
      chk("il_sym2", outs(), 5'b11001);
      chk("il_no_letter", n_letter - b_letter, 0);
      chk("il_no_extra_sym", n_sym - b_sym, 0);
      mark();
      run(7);
      chk("il_letter_early", n_letter - b_letter, 0);
      step();
      chk("il_letter", outs(), 5'b00101);
      run(15);
      chk("il_idle", busy, 1'b0);

      // Key held through reset
      key_in = 1'b1;
      clrn   = 1'b0;
      step();
      step();
      chk("hold_rst", outs(), 5'b00000);
      clrn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("hold_quiet", outs(), 5'b00000);
      end
      key_in = 1'b0;
      mark();
      run(5);
      press(4);
      run(30);
      chk("hold_one_sym", n_sym - b_sym, 1);
      chk("hold_dot", n_dash - b_dash, 0);
      chk("hold_letter", n_letter - b_letter, 1);
      chk("hold_word", n_word - b_word, 1);

      // Reset during PRESS
      key_in = 1'b1;
      run(5);
      chk("mp_busy", busy, 1'b1);
      clrn = 1'b0;
      #1;
      chk("mp_rst_now", outs(), 5'b00000);
      mark();
      step();
      clrn = 1'b1;
      run(3);
      key_in = 1'b0;
      run(30);
      chk("mp_no_sym", n_sym - b_sym, 0);
      chk("mp_idle", busy, 1'b0);

      // Reset during GAP
      press(4);
      run(6);
      chk("mg_busy", busy, 1'b1);
      clrn = 1'b0;
      #1;
      chk("mg_rst_now", outs(), 5'b00000);
      mark();
      step();
      clrn = 1'b1;
      run(30);
      chk("mg_no_letter", n_letter - b_letter, 0);
      chk("mg_no_word", n_word - b_word, 0);

      chk("exclusive_pulses", n_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
